// File: rtl/dip_fast_corner_detect_pkg.sv
// Shared definitions for the FAST-N corner detector: circle geometry and mask type.
package fast_pkg;

    localparam int CIRCLE_N = 16;
    localparam int WIN_DIM  = 7;

    typedef logic [CIRCLE_N-1:0] mask_t;

    // Radius-3 Bresenham circle, p0 at the top centre, walking clockwise.
    localparam int CIRCLE_ROW [CIRCLE_N] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
    localparam int CIRCLE_COL [CIRCLE_N] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

    function automatic int win_pix(input int r, input int c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/dip_fast_corner_detect_arc.sv
// Circular run detector: flags a 16-bit mask holding Pra_Arc_Length or more
// contiguous ones, including runs that wrap from bit 15 back to bit 0.
module fast_arc_detect
    import fast_pkg::*;
#(
    parameter int Pra_Arc_Length = 9
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  mask_t i_mask,
    output logic  o_run_found
);

    logic [CIRCLE_N+Pra_Arc_Length-2:0] mask_ext;
    logic run_ok;
    logic run_found;

    // Extending by the first Arc-1 bits lets every start position see its full window.
    assign mask_ext = {i_mask[Pra_Arc_Length-2:0], i_mask};

    always_comb begin
        run_found = 1'b0;
        run_ok    = 1'b1;
        for (int s = 0; s < CIRCLE_N; s++) begin
            run_ok = 1'b1;
            for (int k = 0; k < Pra_Arc_Length; k++) begin
                run_ok = run_ok & mask_ext[s+k];
            end
            run_found = run_found | run_ok;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_run_found <= 1'b0;
        end else begin
            o_run_found <= run_found;
        end
    end

endmodule

// File: rtl/dip_fast_corner_detect.sv
// FAST-N segment-test corner detector behind the 7x7 window stage; fixed
// 4-cycle latency with vs/hs/en and window coordinates carried alongside.
module dip_fast_corner_detect
    import fast_pkg::*;
#(
    parameter int Pra_Value_Width = 8,
    parameter int Pra_Arc_Length  = 9,
    parameter int Pra_Coord_Width = 12
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_vs,
    input  logic                         i_hs,
    input  logic                         i_en,
    input  logic [49*Pra_Value_Width-1:0] i_window,
    input  logic [Pra_Value_Width-1:0]   i_threshold,
    output logic                         o_vs,
    output logic                         o_hs,
    output logic                         o_pixel_valid,
    output logic                         o_corner,
    output logic [Pra_Value_Width+3:0]   o_score,
    output logic [Pra_Coord_Width-1:0]   o_x,
    output logic [Pra_Coord_Width-1:0]   o_y
);

    localparam int W  = Pra_Value_Width;
    localparam int SW = Pra_Value_Width + 4;
    localparam int CW = Pra_Coord_Width;

    typedef logic [W-1:0] pix_t;
    typedef struct packed {
        logic          vs;
        logic          hs;
        logic          en;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } tag_t;

    logic          vs_was_low, hs_was_low, hs_was_high, line_had_en;
    logic          vs_rise, hs_rise, hs_fall;
    pix_t          t_latched, t_cur;
    logic [CW-1:0] x_cnt, y_cnt, x_cur, y_cur;

    // Edge flags reset to "not seen low", so a frame already in progress at reset release is not mistaken for a new one.
    assign vs_rise = i_vs & vs_was_low;
    assign hs_rise = i_hs & hs_was_low;
    assign hs_fall = ~i_hs & hs_was_high;
    assign t_cur   = vs_rise ? i_threshold : t_latched;
    assign x_cur   = hs_rise ? '0 : x_cnt;
    assign y_cur   = vs_rise ? '0 : y_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_was_low  <= 1'b0;
            hs_was_low  <= 1'b0;
            hs_was_high <= 1'b0;
            line_had_en <= 1'b0;
            t_latched   <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
        end else begin
            vs_was_low  <= ~i_vs;
            hs_was_low  <= ~i_hs;
            hs_was_high <= i_hs;
            if (vs_rise) t_latched <= i_threshold;
            x_cnt <= (i_en && x_cur != '1) ? x_cur + CW'(1) : x_cur;
            y_cnt <= (!vs_rise && hs_fall && line_had_en && y_cur != '1) ? y_cur + CW'(1) : y_cur;
            if (hs_rise)      line_had_en <= i_en;
            else if (i_en)    line_had_en <= 1'b1;
            else if (hs_fall) line_had_en <= 1'b0;
        end
    end

    pix_t       c_in;
    pix_t       p_in [CIRCLE_N];
    logic [W:0] hi_sum;
    logic       window_unused;

    // Only 17 of the 49 window pixels matter; the rest are folded here to mark them intentionally ignored.
    assign window_unused = ^i_window;

    always_comb begin
        c_in = i_window[win_pix(3, 3)*W +: W];
        for (int i = 0; i < CIRCLE_N; i++) begin
            p_in[i] = i_window[win_pix(CIRCLE_ROW[i], CIRCLE_COL[i])*W +: W];
        end
        hi_sum = {1'b0, c_in} + {1'b0, t_cur};
    end

    pix_t s1_p [CIRCLE_N];
    pix_t s1_c, s1_hi, s1_lo;
    logic s1_hi_sat, s1_lo_valid;
    tag_t s1_tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CIRCLE_N; i++) s1_p[i] <= '0;
            s1_c        <= '0;
            s1_hi       <= '0;
            s1_lo       <= '0;
            s1_hi_sat   <= 1'b0;
            s1_lo_valid <= 1'b0;
            s1_tag      <= '0;
        end else begin
            for (int i = 0; i < CIRCLE_N; i++) s1_p[i] <= p_in[i];
            s1_c        <= c_in;
            s1_hi_sat   <= hi_sum[W];
            s1_hi       <= hi_sum[W] ? '1 : hi_sum[W-1:0];
            s1_lo_valid <= (c_in >= t_cur);
            s1_lo       <= c_in - t_cur;
            s1_tag      <= '{vs: i_vs, hs: i_hs, en: i_en, x: x_cur, y: y_cur};
        end
    end

    mask_t bright_c, dark_c;
    pix_t  d_c [CIRCLE_N];

    // Excess over the threshold is p-(c+t) for bright pixels and (c-t)-p for dark ones.
    always_comb begin
        bright_c = '0;
        dark_c   = '0;
        for (int i = 0; i < CIRCLE_N; i++) begin
            bright_c[i] = ~s1_hi_sat & (s1_p[i] > s1_hi);
            dark_c[i]   = s1_lo_valid & (s1_p[i] < s1_lo);
            d_c[i]      = bright_c[i] ? s1_p[i] - s1_hi :
                          dark_c[i]   ? s1_lo - s1_p[i] : '0;
        end
    end

    mask_t s2_bright, s2_dark;
    pix_t  s2_d [CIRCLE_N];
    tag_t  s2_tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_bright <= '0;
            s2_dark   <= '0;
            for (int i = 0; i < CIRCLE_N; i++) s2_d[i] <= '0;
            s2_tag    <= '0;
        end else begin
            s2_bright <= bright_c;
            s2_dark   <= dark_c;
            for (int i = 0; i < CIRCLE_N; i++) s2_d[i] <= d_c[i];
            s2_tag    <= s1_tag;
        end
    end

    logic          bright_run, dark_run;
    logic [SW-1:0] score_sum, s3_score;
    tag_t          s3_tag;

    fast_arc_detect #(.Pra_Arc_Length(Pra_Arc_Length)) u_bright_arc (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_mask      (s2_bright),
        .o_run_found (bright_run)
    );

    fast_arc_detect #(.Pra_Arc_Length(Pra_Arc_Length)) u_dark_arc (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_mask      (s2_dark),
        .o_run_found (dark_run)
    );

    always_comb begin
        score_sum = '0;
        for (int i = 0; i < CIRCLE_N; i++) score_sum = score_sum + SW'(s2_d[i]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s3_score      <= '0;
            s3_tag        <= '0;
            o_vs          <= 1'b0;
            o_hs          <= 1'b0;
            o_pixel_valid <= 1'b0;
            o_corner      <= 1'b0;
            o_score       <= '0;
            o_x           <= '0;
            o_y           <= '0;
        end else begin
            s3_score      <= score_sum;
            s3_tag        <= s2_tag;
            o_vs          <= s3_tag.vs;
            o_hs          <= s3_tag.hs;
            o_pixel_valid <= s3_tag.en;
            o_corner      <= s3_tag.en & (bright_run | dark_run);
            o_score       <= (s3_tag.en & (bright_run | dark_run)) ? s3_score : '0;
            o_x           <= s3_tag.x;
            o_y           <= s3_tag.y;
        end
    end

endmodule

// File: tb/tb_dip_fast_corner_detect.sv
// Self-checking bench for dip_fast_corner_detect: spec vectors, reset and
// threshold sequences, randomized frames against a behavioural model.
module tb_dip_fast_corner_detect;

    localparam int L    = 9;
    localparam int CMAX = 4095;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vs = 1'b0, hs = 1'b0, en = 1'b0;
    logic [391:0] window = '0;
    logic [7:0]   thr = '0;
    logic         o_vs, o_hs, o_pixel_valid, o_corner;
    logic [11:0]  o_score, o_x, o_y;

    always #5 clk = ~clk;

    dip_fast_corner_detect #(
        .Pra_Value_Width(8),
        .Pra_Arc_Length (L),
        .Pra_Coord_Width(12)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_vs         (vs),
        .i_hs         (hs),
        .i_en         (en),
        .i_window     (window),
        .i_threshold  (thr),
        .o_vs         (o_vs),
        .o_hs         (o_hs),
        .o_pixel_valid(o_pixel_valid),
        .o_corner     (o_corner),
        .o_score      (o_score),
        .o_x          (o_x),
        .o_y          (o_y)
    );

    // The bench keeps its own copy of the circle geometry.
    int ROW [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
    int COL [16] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        en;
        logic        corner;
        logic [11:0] score;
        logic [11:0] x;
        logic [11:0] y;
    } out_t;

    typedef struct {
        out_t exp;
        bit   tbl;
        bit   tbl_corner;
        int   tbl_score;
        bit   tbl_xy0;
    } entry_t;

    typedef struct {
        int c;
        int circ [16];
        int t;
        bit corner;
        int score;
    } vec_t;

    entry_t pending [$];
    vec_t   vecs [$];
    int     checks = 0;
    int     errors = 0;

    int m_t = 0, m_x = 0, m_y = 0;
    bit m_vs_low = 0, m_hs_low = 0, m_hs_high = 0, m_line = 0;

    function automatic int pix(input logic [391:0] w, input int r, input int c);
        return int'(w[(r*7+c)*8 +: 8]);
    endfunction

    function automatic int max_run(input bit m [16]);
        int best = 0;
        for (int s = 0; s < 16; s++) begin
            int n = 0;
            while (n < 16 && m[(s+n)%16]) n++;
            if (n > best) best = n;
        end
        return best;
    endfunction

    function automatic void corner_model(input logic [391:0] w, input int t,
                                         output bit corner, output int score);
        bit br [16];
        bit dk [16];
        int c, p;
        c = pix(w, 3, 3);
        score = 0;
        for (int i = 0; i < 16; i++) begin
            p = pix(w, ROW[i], COL[i]);
            br[i] = (c + t <= 255) && (p > c + t);
            dk[i] = (c >= t) && (p < c - t);
            if (br[i]) score += p - c - t;
            else if (dk[i]) score += c - t - p;
        end
        corner = (max_run(br) >= L) || (max_run(dk) >= L);
    endfunction

    function automatic logic [391:0] build_window(input int c, input int circ [16]);
        logic [391:0] w;
        for (int k = 0; k < 49; k++) w[k*8 +: 8] = 8'($urandom);
        w[(3*7+3)*8 +: 8] = 8'(c);
        for (int i = 0; i < 16; i++) w[(ROW[i]*7+COL[i])*8 +: 8] = 8'(circ[i]);
        return w;
    endfunction

    function automatic vec_t mkvec(input int c, input int start, input int n, input int arc_val,
                                   input int rest_val, input int t, input bit cor, input int sc);
        vec_t v;
        v.c = c;
        v.t = t;
        v.corner = cor;
        v.score = sc;
        for (int i = 0; i < 16; i++) v.circ[i] = rest_val;
        for (int k = 0; k < n; k++) v.circ[(start+k)%16] = arc_val;
        return v;
    endfunction

    function automatic logic [391:0] rand_window(input int t);
        int circ [16];
        int c, kind, start, len, v;
        c     = $urandom_range(0, 255);
        kind  = $urandom_range(0, 2);
        start = $urandom_range(0, 15);
        len   = $urandom_range(6, 16);
        for (int i = 0; i < 16; i++) begin
            bit in_arc = ((i - start + 16) % 16) < len;
            if (kind == 1 && in_arc)      v = c + t + $urandom_range(0, 30);
            else if (kind == 2 && in_arc) v = c - t - $urandom_range(0, 30);
            else                          v = c + $urandom_range(0, 2*t) - t;
            circ[i] = (v < 0) ? 0 : (v > 255) ? 255 : v;
        end
        return build_window(c, circ);
    endfunction

    function automatic logic [391:0] vec_window(input vec_t v);
        return build_window(v.c, v.circ);
    endfunction

    task automatic checkZero(input string name);
        checks++;
        if ({o_vs, o_hs, o_pixel_valid, o_corner, o_score, o_x, o_y} !== 40'd0) begin
            errors++;
            $display("[TB] FAIL %s @%0t got vs=%0b hs=%0b en=%0b corner=%0b score=%0d x=%0d y=%0d expected all zero",
                     name, $time, o_vs, o_hs, o_pixel_valid, o_corner, o_score, o_x, o_y);
        end
    endtask

    task automatic checkOutput();
        entry_t e;
        out_t   act;
        if (pending.size() < 4) return;
        e   = pending.pop_front();
        act = {o_vs, o_hs, o_pixel_valid, o_corner, o_score, o_x, o_y};
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL pipe @%0t got vs=%0b hs=%0b en=%0b corner=%0b score=%0d x=%0d y=%0d expected vs=%0b hs=%0b en=%0b corner=%0b score=%0d x=%0d y=%0d",
                     $time, act.vs, act.hs, act.en, act.corner, act.score, act.x, act.y,
                     e.exp.vs, e.exp.hs, e.exp.en, e.exp.corner, e.exp.score, e.exp.x, e.exp.y);
        end
        if (e.tbl) begin
            checks++;
            if (o_corner !== e.tbl_corner || o_score !== e.tbl_score[11:0]) begin
                errors++;
                $display("[TB] FAIL vector @%0t got corner=%0b score=%0d expected corner=%0b score=%0d",
                         $time, o_corner, o_score, e.tbl_corner, e.tbl_score);
            end
        end
        if (e.tbl_xy0) begin
            checks++;
            if (o_x !== 12'd0 || o_y !== 12'd0) begin
                errors++;
                $display("[TB] FAIL coord_origin @%0t got x=%0d y=%0d expected x=0 y=0", $time, o_x, o_y);
            end
        end
    endtask

    task automatic driveInputs(input bit v, input bit h, input bit e, input logic [391:0] w,
                               input int th, input bit tbl = 0, input bit tc = 0,
                               input int ts = 0, input bit xy0 = 0);
        entry_t ent;
        bit vr, hr, hf, cor;
        int sc, xu, yu;
        vs = v; hs = h; en = e; window = w; thr = th[7:0];
        vr = v && m_vs_low;
        hr = h && m_hs_low;
        hf = !h && m_hs_high;
        if (vr) m_t = th & 255;
        xu = hr ? 0 : m_x;
        yu = vr ? 0 : m_y;
        corner_model(w, m_t, cor, sc);
        ent.exp.vs     = v;
        ent.exp.hs     = h;
        ent.exp.en     = e;
        ent.exp.corner = e && cor;
        ent.exp.score  = (e && cor) ? sc[11:0] : 12'd0;
        ent.exp.x      = xu[11:0];
        ent.exp.y      = yu[11:0];
        ent.tbl        = tbl;
        ent.tbl_corner = tc;
        ent.tbl_score  = ts;
        ent.tbl_xy0    = xy0;
        pending.push_back(ent);
        m_y = (!vr && hf && m_line && yu < CMAX) ? yu + 1 : yu;
        m_x = (e && xu < CMAX) ? xu + 1 : xu;
        if (hr)      m_line = e;
        else if (e)  m_line = 1;
        else if (hf) m_line = 0;
        m_vs_low  = !v;
        m_hs_low  = !h;
        m_hs_high = h;
    endtask

    task automatic applyStimulus(input bit v, input bit h, input bit e, input logic [391:0] w,
                                 input int th, input bit tbl = 0, input bit tc = 0,
                                 input int ts = 0, input bit xy0 = 0);
        @(posedge clk);
        #1;
        checkOutput();
        driveInputs(v, h, e, w, th, tbl, tc, ts, xy0);
    endtask

    task automatic resetPulse(input bit v, input bit h, input bit e, input logic [391:0] w, input int th);
        entry_t z;
        @(posedge clk);
        #1;
        checkOutput();
        rst_n = 1'b0;
        #1;
        checkZero("reset_async");
        pending.delete();
        m_t = 0; m_x = 0; m_y = 0;
        m_vs_low = 0; m_hs_low = 0; m_hs_high = 0; m_line = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkZero("reset_hold");
        end
        rst_n = 1'b1;
        z.exp = '0; z.tbl = 0; z.tbl_corner = 0; z.tbl_score = 0; z.tbl_xy0 = 0;
        repeat (3) pending.push_back(z);
        driveInputs(v, h, e, w, th);
    endtask

    initial begin
        vec_t v2, v1;
        int   t, n;

        vecs.push_back(mkvec(100, 0,  0,   0, 100, 20, 0, 0));
        vecs.push_back(mkvec(100, 0,  9, 200, 100, 20, 1, 720));
        vecs.push_back(mkvec(100, 12, 9,  30, 100, 20, 1, 450));
        vecs.push_back(mkvec(100, 0,  8, 200, 100, 20, 0, 0));
        vecs.push_back(mkvec(250, 0,  0,   0, 255, 20, 0, 0));
        vecs.push_back(mkvec(250, 0,  9,   0, 255, 20, 1, 2070));
        vecs.push_back(mkvec(100, 0,  0,   0, 100,  0, 0, 0));
        vecs.push_back(mkvec(100, 0,  9, 101, 100,  0, 1, 9));
        vecs.push_back(mkvec(100, 0,  9, 120, 100, 20, 0, 0));
        vecs.push_back(mkvec(100, 0,  9, 121, 100, 20, 1, 9));
        vecs.push_back(mkvec(100, 0,  9,  80, 100, 20, 0, 0));
        vecs.push_back(mkvec(100, 0,  9,  79, 100, 20, 1, 9));
        vecs.push_back(mkvec(10,  0,  9,   0,  10, 20, 0, 0));
        vecs.push_back(mkvec(100, 5, 16, 200, 100, 20, 1, 1280));
        vecs.push_back(mkvec(100, 3, 12, 200, 100, 20, 1, 960));
        v1 = vecs[0];
        v2 = vecs[1];

        resetPulse(0, 0, 0, '0, 0);
        repeat (3) applyStimulus(0, 0, 0, '0, 0);

        // Each vector opens its own frame with vs and hs rising together.
        foreach (vecs[i]) begin
            applyStimulus(0, 0, 0, rand_window(20), 0);
            applyStimulus(1, 1, 1, vec_window(vecs[i]), vecs[i].t, 1, vecs[i].corner, vecs[i].score, 1);
        end

        // Threshold is held from frame start even when the input changes mid-frame.
        applyStimulus(0, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, rand_window(20), 20);
        applyStimulus(1, 1, 1, vec_window(v1), 200, 1, 0, 0);
        applyStimulus(1, 1, 1, vec_window(v2), 200, 1, 1, 720);
        applyStimulus(1, 1, 0, rand_window(20), 200);

        // Reset mid-line: the still-open frame continues with t=0 until a new vs rising edge.
        resetPulse(1, 1, 1, vec_window(v2), 200);
        repeat (4) applyStimulus(1, 1, 1, rand_window(10), $urandom_range(0, 255));
        applyStimulus(1, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, '0, 0);
        applyStimulus(1, 1, 1, vec_window(v2), 20, 1, 1, 720, 1);
        applyStimulus(1, 1, 1, vec_window(v2), 90);
        applyStimulus(1, 0, 0, '0, 0);

        for (int f = 0; f < 4; f++) begin
            t = $urandom_range(0, 60);
            applyStimulus(0, 0, 0, '0, 0);
            applyStimulus(1, 0, 0, rand_window(t), t);
            for (int ln = 0; ln < 4; ln++) begin
                applyStimulus(1, 0, 0, rand_window(t), $urandom_range(0, 255));
                n = $urandom_range(8, 20);
                for (int k = 0; k < n; k++) begin
                    applyStimulus(1, 1, (ln != 2) && ($urandom_range(0, 3) != 0),
                                  rand_window(t), $urandom_range(0, 255));
                end
                applyStimulus(1, 0, 0, rand_window(t), $urandom_range(0, 255));
            end
        end

        // One very long line drives x into saturation.
        applyStimulus(0, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, '0, 10);
        for (int k = 0; k < 4100; k++) applyStimulus(1, 1, 1, rand_window(10), 10);
        applyStimulus(1, 0, 0, '0, 10);
        repeat (6) applyStimulus(0, 0, 0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
